// File: rtl/mapa_grid.sv
// Game-map cell memory: arbitrated writers, collision-query port, VGA colour port, clear sweep.
// Optional MAPA_ROUND_ROBIN_EN swaps fixed-priority writer arbitration for round-robin.
module mapa_grid #(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30,
  parameter int N_WR        = 3,
  parameter int CELL_BITS   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_WR-1:0]           wr_valid,
  output logic [N_WR-1:0]           wr_ready,
  input  logic [10*N_WR-1:0]        wr_x,
  input  logic [10*N_WR-1:0]        wr_y,
  input  logic [CELL_BITS*N_WR-1:0] wr_dado,
  input  logic                      clear_start,
  output logic                      busy,
  output logic                      erro,
  input  logic                      q_valid,
  input  logic [9:0]                q_x,
  input  logic [9:0]                q_y,
  output logic                      q_rvalid,
  output logic [CELL_BITS-1:0]      q_dado,
  input  logic                      vga_read,
  input  logic [9:0]                vga_x,
  input  logic [9:0]                vga_y,
  output logic [1:0]                mapa_R,
  output logic [1:0]                mapa_G,
  output logic [1:0]                mapa_B
);

  localparam int N_CELLS = MAPA_WIDTH * MAPA_HEIGHT;
  localparam int ADDR_W  = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
  localparam int PTR_W   = (N_WR > 1) ? $clog2(N_WR) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [CELL_BITS-1:0] CELL_NADA = CELL_BITS'(0);
  localparam logic [CELL_BITS-1:0] CELL_OBST = CELL_BITS'(3);
  localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(N_CELLS - 1);

  function automatic logic in_range(input logic [9:0] x, input logic [9:0] y);
    return (x < 10'(MAPA_WIDTH)) && (y < 10'(MAPA_HEIGHT));
  endfunction

  function automatic logic [ADDR_W-1:0] lin_addr(input logic [9:0] x, input logic [9:0] y);
    logic [19:0] full;
    full = 20'(y) * 20'(MAPA_WIDTH) + 20'(x);
    return full[ADDR_W-1:0];
  endfunction

  // Colour packed as {R,G,B}; reserved codes show as dim grey.
  function automatic logic [5:0] cell_rgb(input logic [CELL_BITS-1:0] c);
    logic [5:0] rgb;
    case (c)
      CELL_BITS'(0): rgb = 6'b00_00_00;
      CELL_BITS'(1): rgb = 6'b00_11_00;
      CELL_BITS'(2): rgb = 6'b11_00_00;
      CELL_BITS'(3): rgb = 6'b11_01_00;
      CELL_BITS'(4): rgb = 6'b00_00_11;
      default:       rgb = 6'b01_01_01;
    endcase
    return rgb;
  endfunction

  logic [0:0]           state_r;
  logic [ADDR_W-1:0]    sweep_r;
  logic                 erro_r;
  logic                 q_rvalid_r;
  logic [CELL_BITS-1:0] q_dado_r;
  logic [5:0]           rgb_r;
  logic [CELL_BITS-1:0] mem_r [N_CELLS];

  logic                 busy_s;
  logic                 arb_cand_s;
  logic                 arb_first_s;
  logic                 gnt_any_s;
  logic [PTR_W-1:0]     gnt_idx_s;
  logic [9:0]           gnt_x_s;
  logic [9:0]           gnt_y_s;
  logic [CELL_BITS-1:0] gnt_dado_s;
  logic                 wr_fire_s;
  logic                 wr_ok_s;
  logic [N_WR-1:0]      wr_ready_s;

`ifdef MAPA_ROUND_ROBIN_EN
  logic [PTR_W-1:0]     ptr_r;
`endif

  assign busy_s = (state_r == ST_CLEAR);

  // Arbiter: two passes, first over channels at/after the pointer, then the wrap-around.
  always_comb begin
    arb_cand_s  = 1'b0;
    arb_first_s = 1'b1;
    gnt_any_s   = 1'b0;
    gnt_idx_s   = {PTR_W{1'b0}};
    gnt_x_s     = 10'd0;
    gnt_y_s     = 10'd0;
    gnt_dado_s  = CELL_NADA;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < N_WR; i++) begin
`ifdef MAPA_ROUND_ROBIN_EN
        arb_first_s = (PTR_W'(i) >= ptr_r);
`else
        arb_first_s = 1'b1;
`endif
        arb_cand_s = wr_valid[i] && !gnt_any_s && (arb_first_s == (pass == 0));
        gnt_idx_s  = arb_cand_s ? PTR_W'(i) : gnt_idx_s;
        gnt_x_s    = arb_cand_s ? wr_x[10*i +: 10] : gnt_x_s;
        gnt_y_s    = arb_cand_s ? wr_y[10*i +: 10] : gnt_y_s;
        gnt_dado_s = arb_cand_s ? wr_dado[CELL_BITS*i +: CELL_BITS] : gnt_dado_s;
        gnt_any_s  = gnt_any_s | arb_cand_s;
      end
    end
  end

  assign wr_fire_s = !busy_s && gnt_any_s;
  assign wr_ok_s   = in_range(gnt_x_s, gnt_y_s);

  // One-hot grant; writers are locked out while the sweep runs.
  always_comb begin
    wr_ready_s = {N_WR{1'b0}};
    if (wr_fire_s) begin
      wr_ready_s = N_WR'(1'b1) << gnt_idx_s;
    end else begin
      wr_ready_s = {N_WR{1'b0}};
    end
  end

  assign wr_ready = wr_ready_s;

  // Control FSM: clear sweep sequencing and the sticky range-error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_CLEAR;
      sweep_r <= {ADDR_W{1'b0}};
      erro_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (clear_start) begin
            state_r <= ST_CLEAR;
            sweep_r <= {ADDR_W{1'b0}};
            erro_r  <= 1'b0;
          end else if (wr_fire_s && !wr_ok_s) begin
            erro_r <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (sweep_r == LAST_ADDR) begin
            state_r <= ST_IDLE;
            sweep_r <= {ADDR_W{1'b0}};
          end else begin
            sweep_r <= sweep_r + ADDR_W'(1);
          end
        end
        default: begin
          state_r <= ST_CLEAR;
          sweep_r <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

`ifdef MAPA_ROUND_ROBIN_EN
  // Round-robin pointer moves just past the last granted channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= {PTR_W{1'b0}};
    end else if (wr_fire_s) begin
      ptr_r <= (gnt_idx_s == PTR_W'(N_WR - 1)) ? {PTR_W{1'b0}} : gnt_idx_s + PTR_W'(1);
    end
  end
`endif

  // Single write port: sweep zeroes while busy, otherwise the granted in-range write.
  always_ff @(posedge clk) begin
    if (busy_s) begin
      mem_r[sweep_r] <= CELL_NADA;
    end else if (wr_fire_s && wr_ok_s) begin
      mem_r[lin_addr(gnt_x_s, gnt_y_s)] <= gnt_dado_s;
    end
  end

  // Collision query; off-map coordinates read as walls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_rvalid_r <= 1'b0;
      q_dado_r   <= CELL_NADA;
    end else begin
      q_rvalid_r <= q_valid && !busy_s;
      if (q_valid && !busy_s) begin
        q_dado_r <= in_range(q_x, q_y) ? mem_r[lin_addr(q_x, q_y)] : CELL_OBST;
      end
    end
  end

  // VGA colour lookup; holds its value between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_r <= 6'b00_00_00;
    end else if (vga_read) begin
      if (busy_s || !in_range(vga_x, vga_y)) begin
        rgb_r <= 6'b00_00_00;
      end else begin
        rgb_r <= cell_rgb(mem_r[lin_addr(vga_x, vga_y)]);
      end
    end
  end

  assign busy     = busy_s;
  assign erro     = erro_r;
  assign q_rvalid = q_rvalid_r;
  assign q_dado   = q_dado_r;
  assign mapa_R   = rgb_r[5:4];
  assign mapa_G   = rgb_r[3:2];
  assign mapa_B   = rgb_r[1:0];

endmodule

// File: tb/tb_mapa_grid.sv
// Bench for mapa_grid: cycle-level reference model plus directed scenarios with literal expectations.
module tb_mapa_grid;

  localparam int W  = 40;
  localparam int H  = 30;
  localparam int NW = 3;
  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NW-1:0] wr_valid;
  logic [NW-1:0] wr_ready;
  logic [10*NW-1:0] wr_x;
  logic [10*NW-1:0] wr_y;
  logic [CB*NW-1:0] wr_dado;
  logic          clear_start;
  logic          busy;
  logic          erro;
  logic          q_valid;
  logic [9:0]    q_x;
  logic [9:0]    q_y;
  logic          q_rvalid;
  logic [CB-1:0] q_dado;
  logic          vga_read;
  logic [9:0]    vga_x;
  logic [9:0]    vga_y;
  logic [1:0]    mapa_R;
  logic [1:0]    mapa_G;
  logic [1:0]    mapa_B;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  mapa_grid #(.MAPA_WIDTH(W), .MAPA_HEIGHT(H), .N_WR(NW), .CELL_BITS(CB)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_dado(wr_dado),
    .clear_start(clear_start), .busy(busy), .erro(erro),
    .q_valid(q_valid), .q_x(q_x), .q_y(q_y), .q_rvalid(q_rvalid), .q_dado(q_dado),
    .vga_read(vga_read), .vga_x(vga_x), .vga_y(vga_y),
    .mapa_R(mapa_R), .mapa_G(mapa_G), .mapa_B(mapa_B)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int m_mem [W*H];
  int clr_left;
  int m_erro, m_qv, m_qd, m_rgb, m_ptr;

  function automatic int inr(input int x, input int y);
    return (x < W && y < H) ? 1 : 0;
  endfunction

  function automatic int rgb_of(input int code);
    case (code)
      0: return 6'b000000;
      1: return 6'b001100;
      2: return 6'b110000;
      3: return 6'b110100;
      4: return 6'b000011;
      default: return 6'b010101;
    endcase
  endfunction

  // Winner = first valid channel scanning upward from the priority pointer.
  function automatic int pick(input logic [NW-1:0] v, input int p);
    for (int k = 0; k < NW; k++) begin
      if (v[(p + k) % NW]) return (p + k) % NW;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_left = W * H;
      m_erro = 0; m_qv = 0; m_qd = 0; m_rgb = 0; m_ptr = 0;
      for (int i = 0; i < W * H; i++) m_mem[i] = 0;
    end else begin
      int g, bz, x, y;
      bz = (clr_left > 0) ? 1 : 0;
      g  = bz ? -1 : pick(wr_valid, m_ptr);
      m_qv = (q_valid && !bz) ? 1 : 0;
      if (m_qv == 1) m_qd = inr(int'(q_x), int'(q_y)) ? m_mem[int'(q_y) * W + int'(q_x)] : 3;
      if (vga_read)
        m_rgb = (bz || !inr(int'(vga_x), int'(vga_y))) ? 0 : rgb_of(m_mem[int'(vga_y) * W + int'(vga_x)]);
      if (g >= 0) begin
        x = int'(wr_x[10*g +: 10]);
        y = int'(wr_y[10*g +: 10]);
        if (inr(x, y)) m_mem[y * W + x] = int'(wr_dado[CB*g +: CB]);
        else m_erro = 1;
`ifdef MAPA_ROUND_ROBIN_EN
        m_ptr = (g + 1) % NW;
`endif
      end
      if (bz) clr_left--;
      else if (clear_start) begin
        clr_left = W * H;
        m_erro = 0;
        for (int i = 0; i < W * H; i++) m_mem[i] = 0;
      end
    end
  end

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin
    if (!reset) begin
      int g;
      g = (clr_left > 0) ? -1 : pick(wr_valid, m_ptr);
      chk("busy", int'(busy), (clr_left > 0) ? 1 : 0);
      chk("erro", int'(erro), m_erro);
      chk("q_rvalid", int'(q_rvalid), m_qv);
      chk("q_dado", int'(q_dado), m_qd);
      chk("rgb", int'({mapa_R, mapa_G, mapa_B}), m_rgb);
      chk("wr_ready", int'(wr_ready), (g >= 0) ? (1 << g) : 0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input int x, input int y, input int code);
    wr_x[10*ch +: 10]  = 10'(x);
    wr_y[10*ch +: 10]  = 10'(y);
    wr_dado[CB*ch +: CB] = CB'(code);
  endtask

  task automatic wr(input int ch, input int x, input int y, input int code);
    set_ch(ch, x, y, code);
    wr_valid[ch] = 1'b1;
    #1;
    chk("wr_ready_single", int'(wr_ready), 1 << ch);
    step();
    wr_valid[ch] = 1'b0;
  endtask

  task automatic query(input string nm, input int x, input int y, input int exp);
    q_valid = 1'b1; q_x = 10'(x); q_y = 10'(y);
    step();
    chk("q_rvalid_lit", int'(q_rvalid), 1);
    chk(nm, int'(q_dado), exp);
    q_valid = 1'b0;
  endtask

  task automatic busy_len(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (busy && n < 3000);
    chk(nm, n, W * H);
    step();
  endtask

  initial begin
    int first, other, n;
    reset = 1'b1; wr_valid = '0; wr_x = '0; wr_y = '0; wr_dado = '0;
    clear_start = 1'b0; q_valid = 1'b0; q_x = '0; q_y = '0;
    vga_read = 1'b0; vga_x = '0; vga_y = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 1);
    chk("reset_ready", int'(wr_ready), 0);
    chk("reset_rgb", int'({mapa_R, mapa_G, mapa_B}), 0);
    #1 reset = 1'b0;

    // 1: power-on sweep length, then an empty cell
    busy_len("sweep_len_por");
    query("q_5_5", 5, 5, 0);

    // 2: fruit via channel 1
    wr(1, 10, 10, 2);
    vga_read = 1'b1; vga_x = 10'd10; vga_y = 10'd10;
    step();
    vga_read = 1'b0;
    chk("vga_fruta", int'({mapa_R, mapa_G, mapa_B}), 6'b110000);
    query("q_10_10", 10, 10, 2);

    // 3: contention between channels 0 and 2
`ifdef MAPA_ROUND_ROBIN_EN
    wr(0, 20, 20, 1);
    first = 2; other = 0;
`else
    first = 0; other = 2;
`endif
    set_ch(0, 3, 4, 1);
    set_ch(2, 7, 8, 3);
    wr_valid = 3'b101;
    #1 chk("arb_first", int'(wr_ready), 1 << first);
    step();
    wr_valid[first] = 1'b0;
    #1 chk("arb_second", int'(wr_ready), 1 << other);
    step();
    wr_valid = '0;
    query("q_3_4", 3, 4, 1);
    query("q_7_8", 7, 8, 3);

    // 4: out-of-range write, wall reads, clear
    wr(0, 40, 0, 2);
    chk("erro_set", int'(erro), 1);
    query("q_0_30_wall", 0, 30, 3);
    query("q_0_1_untouched", 0, 1, 0);
    query("q_39_29_corner", 39, 29, 0);
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    chk("erro_cleared", int'(erro), 0);
    chk("clear_busy", int'(busy), 1);
    q_valid = 1'b1; q_x = 10'd3; q_y = 10'd4;
    step();
    q_valid = 1'b0;
    chk("q_dropped_busy", int'(q_rvalid), 0);
    wr_valid = 3'b001;
    #1 chk("ready_busy", int'(wr_ready), 0);
    wr_valid = '0;
    n = 0;
    while (busy && n < 3000) begin step(); n++; end
    chk("clear_done", int'(busy), 0);
    query("q_3_4_cleared", 3, 4, 0);

    // 5: read-during-write sees the old value
    set_ch(0, 2, 2, 4);
    wr_valid = 3'b001;
    q_valid = 1'b1; q_x = 10'd2; q_y = 10'd2;
    vga_read = 1'b1; vga_x = 10'd2; vga_y = 10'd2;
    step();
    wr_valid = '0;
    chk("rdw_q_old", int'(q_dado), 0);
    chk("rdw_vga_old", int'({mapa_R, mapa_G, mapa_B}), 0);
    step();
    chk("rdw_q_new", int'(q_dado), 4);
    chk("rdw_vga_new", int'({mapa_R, mapa_G, mapa_B}), 6'b000011);
    q_valid = 1'b0; vga_read = 1'b0; vga_x = 10'd10; vga_y = 10'd10;
    step();
    chk("vga_hold", int'({mapa_R, mapa_G, mapa_B}), 6'b000011);
    wr(2, 1, 1, 7);
    vga_read = 1'b1; vga_x = 10'd1; vga_y = 10'd1;
    step();
    chk("vga_reserved", int'({mapa_R, mapa_G, mapa_B}), 6'b010101);
    vga_x = 10'd40; vga_y = 10'd5;
    step();
    vga_read = 1'b0;
    chk("vga_oor_black", int'({mapa_R, mapa_G, mapa_B}), 0);

    // 6: reset in the middle of a sweep restarts it
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (600) step();
    chk("mid_sweep_busy", int'(busy), 1);
    reset = 1'b1;
    step();
    step();
    chk("reset_mid_busy", int'(busy), 1);
    reset = 1'b0;
    busy_len("sweep_len_restart");
    query("q_2_2_after", 2, 2, 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, tot_cnt);
    $fatal(1);
  end

endmodule

// File: doc/mapa_grid.md
Name: mapa_grid

Overview:
Parametrised game-map memory, one cell code per grid position, shared by N_WR writer channels (snake 1, snake 2, fruit, obstacle, ...).
- Writers: valid/ready handshake with arbitration; at most one cell write per cycle.
- Collision-query port: 1-cycle read for the game logic.
- VGA colour read port: 1-cycle latency.
- Hardware clear sweep: runs automatically after reset and on request.

Parameters:
MAPA_WIDTH, 40, grid columns (1..1023)
MAPA_HEIGHT, 30, grid rows (1..1023)
N_WR, 3, number of writer channels (1..8); channel 0 has highest fixed priority
CELL_BITS, 4, bits per cell code (>=3)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
wr_valid  in  N_WR  per-channel write request
wr_ready  out  N_WR  per-channel grant; a write completes on valid&ready
wr_x  in  10*N_WR  column per channel, channel i at bits [10i+9:10i]
wr_y  in  10*N_WR  row per channel, same packing
wr_dado  in  CELL_BITS*N_WR  cell code per channel
clear_start  in  1  pulse: start a full-map clear
busy  out  1  clear sweep in progress
erro  out  1  sticky: an out-of-range write was dropped
q_valid  in  1  collision query request
q_x  in  10  query column
q_y  in  10  query row
q_rvalid  out  1  query result valid (1 cycle after accepted q_valid)
q_dado  out  CELL_BITS  queried cell code
vga_read  in  1  VGA pixel-cell read enable
vga_x  in  10  VGA cell column
vga_y  in  10  VGA cell row
mapa_R  out  2  red
mapa_G  out  2  green
mapa_B  out  2  blue

Behaviour:
- Storage: MAPA_WIDTH*MAPA_HEIGHT cells of CELL_BITS. Linear address = y*MAPA_WIDTH + x.
- Cell codes: 0 NADA, 1 COBRA1, 2 FRUTA, 3 OBSTACULO, 4 COBRA2, others reserved.
- Reset values: all colour outputs 0, q_dado 0, q_rvalid 0, erro 0, wr_ready 0. busy=1 immediately, FSM enters CLEAR with sweep address 0.
- FSM, two states:
  - IDLE: clear_start=1 goes to CLEAR with sweep address 0.
  - CLEAR: writes 0 to the sweep address each cycle and increments it. After address W*H-1 is written, goes to IDLE. busy=1 for exactly W*H cycles.
  - clear_start during CLEAR is ignored (no restart).
  - Reset asserted mid-sweep restarts the sweep at 0.
  - Entering CLEAR via clear_start also clears erro.
- Write arbitration, IDLE only:
  - Grant goes to the lowest-index channel with wr_valid=1. wr_ready is combinational from wr_valid and state.
  - Ungranted channels see ready=0 and must hold their request.
  - In CLEAR, all wr_ready=0.
  - Granted write updates the cell at the clock edge.
  - Granted write with x>=MAPA_WIDTH or y>=MAPA_HEIGHT: still handshaken (ready=1), memory unchanged, erro<=1.
- Query port:
  - Accepted when q_valid=1 and not busy.
  - Next cycle: q_rvalid=1 and q_dado = cell value. Out-of-range coordinates return 3 (OBSTACULO, i.e. walls).
  - q_valid while busy: q_rvalid stays 0 and the query is dropped.
- Read/write collision: a query or VGA read in the same cycle as a write to the same cell returns the old value.
- VGA port, 1-cycle latency. When vga_read=1, next-cycle colours (R,G,B) by cell code:
  - 0 -> (00,00,00)
  - 1 -> (00,11,00)
  - 2 -> (11,00,00)
  - 3 -> (11,01,00)
  - 4 -> (00,00,11)
  - reserved -> (01,01,01)
  - Out of range, or busy at read time -> black.
  - When vga_read=0, colour outputs hold their previous values.

Optional Feature:
MAPA_ROUND_ROBIN_EN
- Defined: round-robin arbitration.
  - A pointer names the highest-priority channel and resets to 0.
  - After a grant to channel k, the pointer becomes (k+1) mod N_WR. The pointer is unchanged on cycles with no grant.
- Undefined: fixed priority, channel 0 highest; no pointer register.

Test Plan:
1. Reset, hold all inputs low -> busy=1 for exactly 1200 cycles (40x30), then 0. Query (5,5) -> q_rvalid next cycle, q_dado=0.
2. Channel 1 writes code 2 at (10,10) -> vga_read at (10,10) gives R=11,G=00,B=00 next cycle. Query returns 2.
3. Channels 0 and 2 both valid with codes 1 and 3 at (3,4) and (7,8) -> ch0 granted first, ch2 the next cycle. Cells hold 1 and 3. Round-robin build: after a ch0 grant, a simultaneous ch0/ch2 request grants ch2 first.
4. Write at (40,0) -> ready=1, erro=1, no cell changes. Query (0,30) -> q_dado=3. clear_start -> erro=0, busy=1.
5. Same cycle: write code 4 to (2,2), query (2,2), vga_read (2,2) -> q_dado=0 and black. Repeat next cycle -> q_dado=4 and B=11.
6. Assert reset at sweep address 600 -> busy stays 1, and the sweep completes 1200 cycles after reset release.
